log_fp_mul_serial: RTL and testbench
====================================

Name: log_fp_mul_serial

Overview:
- Parametrised, byte-serial, Mitchell-logarithmic approximate floating-point multiplier. It is the successor to the fixed 16-bit logarithmic multiplier.
- Operands of any sign/exponent/mantissa format whose total width is a multiple of 8 are loaded LSB byte first over two 8-bit lanes.
- The product is computed by log-domain bit-pattern addition and streamed out byte-serially with valid/ready backpressure and exception flags.
- Sits behind the top-level pin wrapper: lanes map to the dedicated/bidirectional input pins, result maps to the output pins.

Parameters:
- EXP_W, 5, exponent field width (>=2).
- MAN_W, 10, mantissa field width (>=1); constraint (1+EXP_W+MAN_W) % 8 == 0.
- BIAS, 2**(EXP_W-1)-1, exponent bias.
- Derived: W = 1+EXP_W+MAN_W; NBYTES = W/8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  clock enable; when 0, all state and outputs hold.
- in_valid  in  1  byte pair present on a_byte/b_byte.
- in_ready  out  1  block accepts a byte pair this cycle.
- a_byte  in  8  operand A byte.
- b_byte  in  8  operand B byte.
- out_valid  out  1  out_byte holds a result byte.
- out_ready  in  1  consumer accepts out_byte.
- out_byte  out  8  result byte, LSB byte first.
- out_last  out  1  high with the final result byte.
- out_flags  out  3  {nan, ovf, unf}; valid whenever out_valid=1; constant for all bytes of one result.

Behaviour:
- Reset (async, any state): state=LOAD, byte counter=0, in_ready=1, out_valid=0, out_byte=0, out_last=0, out_flags=0, operand/result registers=0.
- States: LOAD, CALC, SEND.
- LOAD:
  - in_ready=1.
  - A pair is accepted when in_valid & in_ready & ena; it is written to byte slot cnt of A and B, then cnt++.
  - On acceptance of byte NBYTES-1: cnt<-0, go to CALC.
  - in_valid=0 leaves cnt unchanged (gaps allowed).
- CALC (1 cycle):
  - in_ready=0.
  - Result and flags are registered; the first byte is loaded into out_byte.
  - out_valid=1 and out_last=(NBYTES==1) on the next cycle; go to SEND.
- Latency: first out_valid is 2 cycles after the edge that accepted the last input byte.
- SEND:
  - in_ready=0; input lanes are ignored.
  - A byte transfers when out_valid & out_ready & ena; the next byte is then presented.
  - out_byte, out_last and out_flags are held stable while out_ready=0.
  - After the transfer with out_last=1: out_valid=0, out_last=0, go to LOAD; in_ready=1 the following cycle.
- Arithmetic: sA, eA, mA are the fields of A (likewise B); s = sA ^ sB. Evaluate in priority order:
  1. NaN: either input has e=all-ones and m!=0, or inf times zero/subnormal. Result {s, all-ones, 1<<(MAN_W-1)}; nan=1.
  2. Either input inf: result {s, all-ones, 0}; no flag.
  3. Either input e==0 (zero/subnormal, flushed): result {s, 0, 0}; no flag.
  4. Otherwise compute R = {eA,mA} + {eB,mB} - (BIAS<<MAN_W), signed, width EXP_W+MAN_W+2. The mantissa carry into the exponent gives exact Mitchell antilog behaviour.
     - R >= (2**EXP_W - 1)<<MAN_W: result {s, all-ones, 0}; ovf=1.
     - R < (1<<MAN_W), including negative R: result {s, 0, 0}; unf=1.
     - Else result {s, R[EXP_W+MAN_W-1:0]}.
- No rounding; truncation is inherent to the log approximation.
- Simultaneous events: in SEND, in_valid is ignored regardless of out_ready. The last-byte handoff and a new in_valid in the same cycle do not overlap, because in_ready=0 in that cycle.
- ena=0 mid-load or mid-send: freezes counters and outputs; resumes exactly on ena=1.
- rst_n low mid-load or mid-send: partial operands and the pending result are discarded; the next accepted pair is byte 0.

Test Plan:
1. Default FP16: A=0x3E00, B=0x4200 (1.5x3.0).
   - Stimulus: pairs (00,00) then (3E,42), in_valid=1, out_ready=1.
   - Required: out_byte 0x00 then 0x44 (result 0x4400 = 4.0), out_last on the second byte, flags=000, first out_valid 2 cycles after the second accept.
2. Specials:
   - 0xC000 x 0x0000 -> 0x8000, flags 000.
   - 0x7C00 x 0x0000 -> 0x7E00, nan=1.
   - 0x7C00 x 0xC000 -> 0xFC00, flags 000.
3. Range:
   - 0x7800 x 0x7800 -> 0x7C00, ovf=1.
   - 0x0400 x 0x0400 -> 0x0000, unf=1.
4. Backpressure: during case 1, hold out_ready=0 for 3 cycles after out_valid.
   - out_byte stays 0x00, in_ready=0, and lane toggling has no effect.
   - After release, bytes 00,44 follow and in_ready=1 one cycle after the last transfer.
5. Reset and enable:
   - Deassert rst_n for 1 cycle after byte 0 of A is accepted. Next pairs (00,00),(3E,42) still yield 0x4400.
   - Drop ena for 2 cycles between bytes. Same result, latency extended by 2.
6. FP8 instance (EXP_W=4, MAN_W=3, NBYTES=1):
   - 0x38 x 0x40 (1.0x2.0) -> 0x40 with out_last=1 on the single byte.
   - 0x3C x 0x3C (1.5x1.5) -> 0x40 (Mitchell gives 2.0).

Source files
------------

// File: rtl/log_fp_mul_serial.sv
// Byte-serial Mitchell-logarithmic floating-point multiplier.
// Operands arrive LSB byte first on two 8-bit lanes. The product is formed by
// adding the {exp,man} bit patterns and removing one bias. The result is
// streamed back LSB byte first with valid/ready handshaking and exception flags.
module log_fp_mul_serial #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a_byte,
  input  logic [7:0] b_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic [2:0] out_flags
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int NBYTES = W / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int RW     = EXP_W + MAN_W + 2;

  localparam logic [CW-1:0]        LAST_IDX = CW'(NBYTES - 1);
  localparam logic signed [RW-1:0] BIAS_SH  = RW'(BIAS) << MAN_W;
  localparam logic signed [RW-1:0] OVF_TH   = RW'((2**EXP_W) - 1) << MAN_W;
  localparam logic signed [RW-1:0] UNF_TH   = RW'(1) << MAN_W;
  localparam logic [MAN_W-1:0]     QNAN_M   = MAN_W'(1) << (MAN_W - 1);

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_SEND} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a, r_b, r_res;
  logic [2:0]      r_flags;
  logic [7:0]      r_out_byte;
  logic            r_out_valid, r_out_last, r_in_ready;

  logic [EXP_W-1:0]       w_ea, w_eb;
  logic [MAN_W-1:0]       w_ma, w_mb;
  logic                   w_s;
  logic                   w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic signed [RW-1:0]   w_r;
  logic [W-1:0]           w_res;
  logic [2:0]             w_flags;
  logic [W-1:0]           w_next_sh;

  assign w_ea = r_a[W-2:MAN_W];
  assign w_eb = r_b[W-2:MAN_W];
  assign w_ma = r_a[MAN_W-1:0];
  assign w_mb = r_b[MAN_W-1:0];
  assign w_s  = r_a[W-1] ^ r_b[W-1];

  assign w_a_nan  = (&w_ea) & (|w_ma);
  assign w_b_nan  = (&w_eb) & (|w_mb);
  assign w_a_inf  = (&w_ea) & ~(|w_ma);
  assign w_b_inf  = (&w_eb) & ~(|w_mb);
  assign w_a_zero = ~(|w_ea);
  assign w_b_zero = ~(|w_eb);

  // Log-domain product; the mantissa carry ripples into the exponent naturally
  assign w_r = $signed({2'b00, r_a[W-2:0]}) + $signed({2'b00, r_b[W-2:0]}) - BIAS_SH;

  // Special cases in priority order, then range-check the pattern sum
  always_comb begin
    w_res   = '0;
    w_flags = 3'b000;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_res   = {w_s, {EXP_W{1'b1}}, QNAN_M};
      w_flags = 3'b100;
    end else if (w_a_inf || w_b_inf) begin
      w_res = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero || w_b_zero) begin
      w_res = {w_s, {(W-1){1'b0}}};
    end else if (w_r >= OVF_TH) begin
      w_res   = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags = 3'b010;
    end else if (w_r < UNF_TH) begin
      w_res   = {w_s, {(W-1){1'b0}}};
      w_flags = 3'b001;
    end else begin
      w_res = {w_s, w_r[W-2:0]};
    end
  end

  // Byte following the one currently presented
  assign w_next_sh = r_res >> (8 * (int'(r_cnt) + 1));

  // Load/compute/send sequencer; every register freezes while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_flags     <= 3'b000;
      r_out_byte  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (ena) begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_a[r_cnt*8 +: 8] <= a_byte;
            r_b[r_cnt*8 +: 8] <= b_byte;
            if (r_cnt == LAST_IDX) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_CALC;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_CALC: begin
          r_res       <= w_res;
          r_flags     <= w_flags;
          r_out_byte  <= w_res[7:0];
          r_out_valid <= 1'b1;
          r_out_last  <= (NBYTES == 1);
          r_cnt       <= '0;
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_cnt       <= '0;
              r_state     <= S_LOAD;
            end else begin
              r_out_byte <= w_next_sh[7:0];
              r_out_last <= (int'(r_cnt) + 2 == NBYTES);
              r_cnt      <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_last  = r_out_last;
  assign out_flags = r_flags;

endmodule

// File: tb/tb_log_fp_mul_serial.sv
// Directed bench for log_fp_mul_serial: FP16 default instance plus FP8 instance.
module tb_log_fp_mul_serial;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // FP16 instance signals
  logic       rst_n, ena, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [7:0] a_byte, b_byte, out_byte;
  logic [2:0] out_flags;

  // FP8 instance signals
  logic       f_rst_n, f_ena, f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_out_last;
  logic [7:0] f_a_byte, f_b_byte, f_out_byte;
  logic [2:0] f_out_flags;

  log_fp_mul_serial dut16 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .a_byte(a_byte), .b_byte(b_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last), .out_flags(out_flags)
  );

  log_fp_mul_serial #(.EXP_W(4), .MAN_W(3)) dut8 (
    .clk(clk), .rst_n(f_rst_n), .ena(f_ena), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .a_byte(f_a_byte), .b_byte(f_b_byte), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_byte(f_out_byte), .out_last(f_out_last), .out_flags(f_out_flags)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive two byte pairs, each accepted at the following rising edge
  task automatic send16(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a_byte   = a[i*8 +: 8];
      b_byte   = b[i*8 +: 8];
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  // Count rising edges (starting from 'start') until out_valid is seen; ends at a negedge
  task automatic wait16(input int start, output int lat);
    lat = start;
    @(negedge clk);
    while (!out_valid && lat < start + 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Collect both result bytes; must be called at a negedge
  task automatic recv16(output logic [15:0] res, output logic [2:0] fl, output logic [1:0] lasts);
    res   = '0;
    fl    = '0;
    lasts = '0;
    for (int i = 0; i < 2; i++) begin
      int t = 0;
      if (i > 0) @(negedge clk);
      while (!out_valid && t < 10) begin
        @(negedge clk);
        t++;
      end
      if (t >= 10) chk("recv_timeout", 32'd0, 32'd1);
      res[i*8 +: 8] = out_byte;
      lasts[i]      = out_last;
      if (i == 0) fl = out_flags;
      else if (out_flags !== fl) chk("flags_stable", {29'd0, out_flags}, {29'd0, fl});
      @(posedge clk);
    end
    @(negedge clk);
    chk("in_ready_after_send", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_send", {31'd0, out_valid}, 32'd0);
  endtask

  // Single-byte FP8 transaction with full check
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_r,
                      input logic [2:0] exp_f, input string nm);
    int lat;
    @(negedge clk);
    f_in_valid = 1'b1;
    f_a_byte   = a;
    f_b_byte   = b;
    @(posedge clk);
    #1 f_in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!f_out_valid && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({nm, "_lat"}, lat, 32'd2);
    chk({nm, "_res"}, {24'd0, f_out_byte}, {24'd0, exp_r});
    chk({nm, "_last"}, {31'd0, f_out_last}, 32'd1);
    chk({nm, "_flags"}, {29'd0, f_out_flags}, {29'd0, exp_f});
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_idle"}, {30'd0, f_out_valid, f_in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  fl;
    string       nm;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] res;
    logic [2:0]  fl;
    logic [1:0]  lasts;
    int          lat;

    // Hand-computed from bit-pattern sum minus 0x3C00
    vecs[0] = '{16'h3E00, 16'h4200, 16'h4400, 3'b000, "mul_1p5x3"};
    vecs[1] = '{16'hC000, 16'h0000, 16'h8000, 3'b000, "neg_x_zero"};
    vecs[2] = '{16'h7C00, 16'h0000, 16'h7E00, 3'b100, "inf_x_zero"};
    vecs[3] = '{16'h7C00, 16'hC000, 16'hFC00, 3'b000, "inf_x_neg"};
    vecs[4] = '{16'h7800, 16'h7800, 16'h7C00, 3'b010, "overflow"};
    vecs[5] = '{16'h0400, 16'h0400, 16'h0000, 3'b001, "underflow"};
    vecs[6] = '{16'h3C00, 16'hBC00, 16'hBC00, 3'b000, "one_x_negone"};
    vecs[7] = '{16'h7C01, 16'h3C00, 16'h7E00, 3'b100, "nan_in"};

    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_byte = 8'h00; b_byte = 8'h00;
    f_rst_n = 1'b0; f_ena = 1'b1; f_in_valid = 1'b0; f_out_ready = 1'b1; f_a_byte = 8'h00; f_b_byte = 8'h00;

    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    f_rst_n = 1'b1;

    // Table-driven FP16 vectors
    for (int i = 0; i < 8; i++) begin
      send16(vecs[i].a, vecs[i].b);
      wait16(1, lat);
      chk({vecs[i].nm, "_lat"}, lat, 32'd2);
      recv16(res, fl, lasts);
      chk({vecs[i].nm, "_res"}, {16'd0, res}, {16'd0, vecs[i].res});
      chk({vecs[i].nm, "_flags"}, {29'd0, fl}, {29'd0, vecs[i].fl});
      chk({vecs[i].nm, "_last"}, {30'd0, lasts}, 32'd2);
    end

    // Backpressure: hold out_ready low for 3 cycles while lanes toggle
    out_ready = 1'b0;
    send16(16'h3E00, 16'h4200);
    wait16(1, lat);
    chk("bp_lat", lat, 32'd2);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_byte", {24'd0, out_byte}, 32'd0);
      chk("bp_hold_last", {31'd0, out_last}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1;
      a_byte   = 8'($urandom);
      b_byte   = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    recv16(res, fl, lasts);
    chk("bp_res", {16'd0, res}, 32'h4400);
    chk("bp_last", {30'd0, lasts}, 32'd2);

    // Reset after a stray first byte: next pairs must start at byte 0
    @(negedge clk);
    in_valid = 1'b1; a_byte = 8'h11; b_byte = 8'h22;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send16(16'h3E00, 16'h4200);
    wait16(1, lat);
    recv16(res, fl, lasts);
    chk("rst_mid_res", {16'd0, res}, 32'h4400);

    // ena low for 2 cycles between bytes, then 2 cycles while a byte is offered
    @(negedge clk);
    in_valid = 1'b1; a_byte = 8'h00; b_byte = 8'h00;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0; a_byte = 8'h3E; b_byte = 8'h42;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ena = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    // edges from first accept: byte0, two frozen, byte1, calc
    wait16(4, lat);
    chk("ena_total_edges", lat, 32'd5);
    ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("ena_send_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("ena_send_hold_byte", {24'd0, out_byte}, 32'd0);
    ena = 1'b1;
    recv16(res, fl, lasts);
    chk("ena_res", {16'd0, res}, 32'h4400);
    chk("ena_last", {30'd0, lasts}, 32'd2);

    // FP8 instance, single byte per operand
    run8(8'h38, 8'h40, 8'h40, 3'b000, "fp8_1x2");
    run8(8'h3C, 8'h3C, 8'h40, 3'b000, "fp8_1p5x1p5");
    run8(8'h70, 8'h70, 8'h78, 3'b010, "fp8_ovf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
